// File: rtl/operand_sequencer.sv
// Queues add/subtract commands and presents each operand set to a multi-cycle datapath.
// Each set is held for HOLD_CYCLES cycles, then the result is captured behind a valid/ready port.
module operand_sequencer #(
    parameter int WORDSIZE    = 64,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [WORDSIZE-1:0] cmd_num1,
    input  logic [WORDSIZE-1:0] cmd_num2,
    input  logic                cmd_op,
    output logic [WORDSIZE-1:0] num1,
    output logic [WORDSIZE-1:0] num2,
    output logic                operation_in,
    input  logic [WORDSIZE-1:0] result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WORDSIZE-1:0] res_data,
    output logic                busy,
    output logic [1:0]          state_dbg
);
    // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid, once raised, holds its payload steady until that edge.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int EW = 2 * WORDSIZE + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [WORDSIZE-1:0]   num1_q, num1_d, num2_q, num2_d;
    logic                  op_q, op_d;
    logic                  res_valid_q, res_valid_d;
    logic [WORDSIZE-1:0]   res_data_q, res_data_d;
    logic                  push, pop;

    // Ready depends only on the registered count, never on the FSM.
    assign cmd_ready = (count_q < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop                    = 1'b1;
                    {num1_d, num2_d, op_d} = mem_q[rd_ptr_q];
                    hold_cnt_d             = '0;
                    state_d                = HOLD;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                res_data_d  = result;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_cnt_q  <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            op_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_cnt_q  <= hold_cnt_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            op_q        <= op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_num1, cmd_num2, cmd_op};
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign operation_in = op_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign busy         = (state_q != IDLE);
    assign state_dbg    = state_q;

endmodule
